// File: rtl/one_time_pad.sv
// One-time-pad cipher stage: registered XOR of each valid word with a key register.
// Define OTP_KEY_ROTATE_EN to advance the key by one LFSR step after every accepted word.
module one_time_pad #(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] DEFAULT_KEY = WIDTH'(32'hA5C35A3C)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] mensagem,
    input  logic             mensagem_valida,
    input  logic [WIDTH-1:0] chave,
    input  logic             carregar_chave,
    output logic [WIDTH-1:0] mensagemCifrada,
    output logic             mensagem_cifrada_valida,
    output logic [15:0]      palavras_processadas
);

    logic [WIDTH-1:0] key;
    logic [WIDTH-1:0] loadValue;
    logic [WIDTH-1:0] nextKey;
    logic [15:0]      nextCount;

    always_comb begin
        // A zero key would make the pad transparent, so it is replaced by the default.
        loadValue = (chave == '0) ? DEFAULT_KEY : chave;
        nextCount = (palavras_processadas == '1) ? palavras_processadas
                                                 : palavras_processadas + 16'd1;
`ifdef OTP_KEY_ROTATE_EN
        nextKey = {key[WIDTH-2:0], key[WIDTH-1] ^ key[21] ^ key[1] ^ key[0]};
`else
        nextKey = key;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            key                     <= DEFAULT_KEY;
            mensagemCifrada         <= '0;
            mensagem_cifrada_valida <= 1'b0;
            palavras_processadas    <= '0;
        end else begin
            mensagem_cifrada_valida <= mensagem_valida;
            if (mensagem_valida) begin
                mensagemCifrada <= mensagem ^ key;
            end
            // A load wins over counting and rotation; a concurrent word still uses the old key.
            if (carregar_chave) begin
                key                  <= loadValue;
                palavras_processadas <= '0;
            end else if (mensagem_valida) begin
                key                  <= nextKey;
                palavras_processadas <= nextCount;
            end
        end
    end

endmodule

// File: tb/tb_one_time_pad.sv
// Bench for one_time_pad: a cipher instance chained into a decipher instance, checked every
// cycle against a behavioural model, plus directed literal expectations.
module tb_one_time_pad;

    localparam logic [31:0] DEF = 32'hA5C35A3C;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] mensagem;
    logic        mensagem_valida;
    logic [31:0] chave;
    logic        carregar_chave;

    logic [31:0] aOut, bOut;
    logic        aVal, bVal;
    logic [15:0] aCnt, bCnt;

    // The decipher instance sees key loads one cycle later, matching its one-cycle-late data.
    logic        bLoad;
    logic [31:0] bChave;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    one_time_pad #(.WIDTH(32), .DEFAULT_KEY(DEF)) dutA (
        .clock(clock), .reset(reset),
        .mensagem(mensagem), .mensagem_valida(mensagem_valida),
        .chave(chave), .carregar_chave(carregar_chave),
        .mensagemCifrada(aOut), .mensagem_cifrada_valida(aVal),
        .palavras_processadas(aCnt)
    );

    one_time_pad #(.WIDTH(32), .DEFAULT_KEY(DEF)) dutB (
        .clock(clock), .reset(reset),
        .mensagem(aOut), .mensagem_valida(aVal),
        .chave(bChave), .carregar_chave(bLoad),
        .mensagemCifrada(bOut), .mensagem_cifrada_valida(bVal),
        .palavras_processadas(bCnt)
    );

    always @(posedge clock) begin
        if (reset) begin
            bLoad  <= 1'b0;
            bChave <= '0;
        end else begin
            bLoad  <= carregar_chave;
            bChave <= chave;
        end
    end

    function automatic logic [31:0] lfsrNext(input logic [31:0] k);
        return {k[30:0], k[31] ^ k[21] ^ k[1] ^ k[0]};
    endfunction

    function automatic logic [31:0] keyAfter(input logic [31:0] k, input int words);
        logic [31:0] r = k;
`ifdef OTP_KEY_ROTATE_EN
        for (int i = 0; i < words; i++) r = lfsrNext(r);
`endif
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: cipher state plus the plaintext the decipher must reproduce.
    logic        started = 1'b0;
    logic [31:0] mKey, mOut, bExpOut, aWordPrev;
    logic        mVal, bExpVal, aValPrev;
    int          mCnt, bExpCnt;

    always @(posedge clock) begin
        if (reset) begin
            started  = 1'b1;
            mKey     = DEF;
            mOut     = '0;
            mVal     = 1'b0;
            mCnt     = 0;
            bExpOut  = '0;
            bExpVal  = 1'b0;
            bExpCnt  = 0;
            aValPrev = 1'b0;
        end else if (started) begin
            bExpVal = aValPrev;
            if (aValPrev) bExpOut = aWordPrev;
            if (bLoad) bExpCnt = 0;
            else if (aValPrev && bExpCnt < 65535) bExpCnt++;

            aValPrev = mensagem_valida;
            if (mensagem_valida) aWordPrev = mensagem;

            mVal = mensagem_valida;
            if (mensagem_valida) mOut = mensagem ^ mKey;
            if (carregar_chave) begin
                mKey = (chave == 32'h0) ? DEF : chave;
                mCnt = 0;
            end else if (mensagem_valida) begin
                if (mCnt < 65535) mCnt++;
                mKey = keyAfter(mKey, 1);
            end
        end
    end

    always @(negedge clock) begin
        if (started) begin
            chk("aOut", aOut, mOut);
            chk("aVal", {31'b0, aVal}, {31'b0, mVal});
            chk("aCnt", {16'b0, aCnt}, 32'(mCnt));
            chk("bOut", bOut, bExpOut);
            chk("bVal", {31'b0, bVal}, {31'b0, bExpVal});
            chk("bCnt", {16'b0, bCnt}, 32'(bExpCnt));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic setIn(input logic r, input logic v, input logic [31:0] m,
                         input logic l, input logic [31:0] c);
        reset           = r;
        mensagem_valida = v;
        mensagem        = m;
        carregar_chave  = l;
        chave           = c;
    endtask

    initial begin
        logic [31:0] k;
        setIn(1'b1, 1'b0, '0, 1'b0, '0);
        tick(); tick();
        chk("rst_out", aOut, 32'h0);
        chk("rst_val", {31'b0, aVal}, 32'h0);
        chk("rst_cnt", {16'b0, aCnt}, 32'h0);

        setIn(1'b0, 1'b1, 32'h67616C6F, 1'b0, '0);
        tick();
        chk("galo_out", aOut, 32'hC2A23653);
        chk("galo_val", {31'b0, aVal}, 32'h1);
        chk("galo_cnt", {16'b0, aCnt}, 32'h1);
        setIn(1'b0, 1'b0, '0, 1'b0, '0);
        tick();
        chk("chain_out", bOut, 32'h67616C6F);
        chk("chain_val", {31'b0, bVal}, 32'h1);
        chk("hold_out", aOut, 32'hC2A23653);

        setIn(1'b0, 1'b0, '0, 1'b1, 32'hFFFFFFFF);
        tick();
        chk("load_cnt", {16'b0, aCnt}, 32'h0);
        setIn(1'b0, 1'b1, 32'h0000FFFF, 1'b0, '0);
        tick();
        chk("ffkey_out", aOut, 32'hFFFF0000);
        chk("ffkey_cnt", {16'b0, aCnt}, 32'h1);

        setIn(1'b1, 1'b0, '0, 1'b0, '0);
        tick();
        setIn(1'b0, 1'b1, 32'h12345678, 1'b1, 32'h0);
        tick();
        chk("zload_out", aOut, 32'hB7F70C44);
        chk("zload_cnt", {16'b0, aCnt}, 32'h0);
        setIn(1'b0, 1'b1, 32'h0, 1'b0, '0);
        tick();
        chk("zero1_out", aOut, 32'hA5C35A3C);
        tick();
`ifdef OTP_KEY_ROTATE_EN
        chk("zero2_out", aOut, 32'h4B86B479);
`else
        chk("zero2_out", aOut, 32'hA5C35A3C);
`endif
        chk("zero2_cnt", {16'b0, aCnt}, 32'h2);

        // Three back-to-back words, then idle: valid drops, data holds.
        setIn(1'b1, 1'b0, '0, 1'b0, '0);
        tick();
        for (int i = 0; i < 3; i++) begin
            setIn(1'b0, 1'b1, 32'h11111111 * (i + 1), 1'b0, '0);
            tick();
            chk("stream_out", aOut, (32'h11111111 * (i + 1)) ^ keyAfter(DEF, i));
            chk("stream_val", {31'b0, aVal}, 32'h1);
        end
        k = keyAfter(DEF, 2);
        setIn(1'b0, 1'b0, '0, 1'b0, '0);
        tick();
        chk("idle_val", {31'b0, aVal}, 32'h0);
        chk("idle_hold", aOut, 32'h33333333 ^ k);

        setIn(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, '0);
        tick();
        setIn(1'b1, 1'b1, 32'hCAFEF00D, 1'b0, '0);
        tick();
        chk("midrst_out", aOut, 32'h0);
        chk("midrst_val", {31'b0, aVal}, 32'h0);
        setIn(1'b0, 1'b0, '0, 1'b0, '0);
        tick();
        chk("midrst_bval", {31'b0, bVal}, 32'h0);
        chk("midrst_bout", bOut, 32'h0);

        // Counter saturation.
        setIn(1'b1, 1'b0, '0, 1'b0, '0);
        tick();
        for (int i = 0; i < 65534; i++) begin
            setIn(1'b0, 1'b1, $urandom, 1'b0, '0);
            tick();
        end
        chk("sat_fffe", {16'b0, aCnt}, 32'h0000FFFE);
        setIn(1'b0, 1'b1, $urandom, 1'b0, '0);
        tick();
        chk("sat_ffff", {16'b0, aCnt}, 32'h0000FFFF);
        setIn(1'b0, 1'b1, $urandom, 1'b0, '0);
        tick();
        chk("sat_hold", {16'b0, aCnt}, 32'h0000FFFF);

        for (int i = 0; i < 3000; i++) begin
            setIn($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 75, $urandom,
                  $urandom_range(0, 99) < 5,
                  ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom);
            tick();
        end

        setIn(1'b0, 1'b0, '0, 1'b0, '0);
        tick(); tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/one_time_pad.md
Name: one_time_pad

Overview:
- Registered 32-bit one-time-pad cipher: each accepted word is XORed with a 32-bit key register.
- Encryption and decryption are the same operation. Two instances in series with the same key recover the original word.
- Sits in the datapath as a streaming valid-qualified stage, one word per clock.

Parameters:
- WIDTH, 32, data and key width in bits (all ports below use WIDTH; only 32 is verified).
- DEFAULT_KEY, 32'hA5C35A3C, key value after reset and when a zero key is loaded.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- mensagem  input  WIDTH  plaintext or ciphertext word in
- mensagem_valida  input  1  mensagem is valid this cycle
- chave  input  WIDTH  new key value
- carregar_chave  input  1  load chave into key register this cycle
- mensagemCifrada  output  WIDTH  result word (mensagem XOR key)
- mensagem_cifrada_valida  output  1  mensagemCifrada valid this cycle
- palavras_processadas  output  16  count of words processed since reset or last key load

Behaviour:
- Reset (synchronous, reset=1 at rising edge):
  - key <= DEFAULT_KEY
  - mensagemCifrada <= 0
  - mensagem_cifrada_valida <= 0
  - palavras_processadas <= 0
  - reset overrides all other inputs in that cycle.
- Latency is 1 cycle. If mensagem_valida=1 at edge N, then after edge N:
  - mensagemCifrada = mensagem ^ key, using the key value held before edge N
  - mensagem_cifrada_valida = 1.
- If mensagem_valida=0 at an edge:
  - mensagem_cifrada_valida <= 0
  - mensagemCifrada holds its last value (not cleared).
- No backpressure: the block accepts one word every cycle unconditionally.
- Key load (carregar_chave=1):
  - key <= chave at the edge; a zero chave loads DEFAULT_KEY instead.
  - palavras_processadas <= 0.
- Simultaneous key load and mensagem_valida: the word uses the OLD key, and the new key applies from the next word. The counter becomes 0; the concurrent word is not counted.
- palavras_processadas increments by 1 per accepted word and saturates at 16'hFFFF.
- Involution: feeding a result word back with the same key yields the original word exactly.
- Purely bitwise: no carries, no width growth.
- Reset asserted mid-stream drops any in-flight word; valid is 0 the cycle after reset.

Optional Feature:
- Macro: OTP_KEY_ROTATE_EN.
- Defined:
  - After every accepted word (and not on a key-load cycle), key advances one LFSR step: key <= {key[30:0], key[31]^key[21]^key[1]^key[0]}.
  - A fresh pad is used per word. Two instances loaded with the same key stay in lockstep if fed the same valid sequence, so decryption still recovers the plaintext.
  - A key of zero cannot occur, because loading zero substitutes DEFAULT_KEY.
- Not defined: key stays constant until reloaded or reset.

Test Plan:
- Reset, then mensagem=32'h67616C6F ("galo"), valid=1 -> next cycle mensagemCifrada=32'hC2A23653, valid=1, count=1.
- Chain two instances, both reset, input 32'h67616C6F -> second instance outputs 32'h67616C6F two cycles after input.
- Load chave=32'hFFFFFFFF, then send 32'h0000FFFF -> output 32'hFFFF0000, and count is 0 after the load and 1 after the word.
- Same-cycle load chave=32'h0 with mensagem=32'h12345678 valid -> output 32'h12345678^32'hA5C35A3C=32'hB7F70C44, and the key stays DEFAULT_KEY.
- Back-to-back valid words for 3 cycles, then valid=0 -> three consecutive valid outputs, then valid drops and data holds. Assert reset during a stream -> outputs zero next cycle.
- With OTP_KEY_ROTATE_EN: send 32'h0 twice after reset -> outputs are 32'hA5C35A3C, then the LFSR-next key. A chained pair recovers both words.
